// File: rtl/data_mem_bank_if.sv
`default_nettype none
// ============================================================================
// data_mem_bank_if : load/store/clear bus between datapath and data_mem_bank
// Rev 1.0
// ============================================================================
interface data_mem_bank_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 20
);
   localparam int c_NB = DATA_W / 8;

   logic              str;
   logic              ld;
   logic [c_NB-1:0]   sel;
   logic [1:0]        ld_ext;
   logic              clr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              busy;
   logic              addr_err;
   logic              fmt_err;

   modport master (
      output str, ld, sel, ld_ext, clr, addr, data_in,
      input  data_out, rd_valid, busy, addr_err, fmt_err
   );

   modport slave (
      input  str, ld, sel, ld_ext, clr, addr, data_in,
      output data_out, rd_valid, busy, addr_err, fmt_err
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_bank.sv
`default_nettype none
// ============================================================================
// data_mem_bank : byte-lane data memory with extending loads and clear sweep
// Rev 1.0
// ============================================================================
module data_mem_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 20,
   parameter int DEPTH  = 1024
) (
   input  wire logic        clk,
   input  wire logic        rst,
   data_mem_bank_if.slave   mem_if
);
   localparam int                c_NB    = DATA_W / 8;
   localparam int                c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [c_PTR_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                rd_valid_q, rd_valid_d;
   logic                addr_err_q, addr_err_d;
   logic                fmt_err_q, fmt_err_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                w_in_range;
   logic [c_PTR_W-1:0]  w_idx;
   logic [DATA_W-1:0]   w_rd_word;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   w_raw;
   logic                w_is_ext;
   logic                w_legal;
   int                  w_off;
   int                  w_fw;
   logic [DATA_W-1:0]   w_shift;
   logic                w_msb;
   logic                w_sign;
   logic [DATA_W-1:0]   w_ext_word;
   logic [DATA_W-1:0]   w_load_res;
   logic [c_NB-1:0]     w_we;
   logic [c_PTR_W-1:0]  w_waddr;
   logic [DATA_W-1:0]   w_wdata;

   assign w_in_range = ({1'b0, mem_if.addr} < c_DEPTH);
   assign w_idx      = mem_if.addr[c_PTR_W-1:0];
   // Guard keeps a truncated out-of-range index from ever touching the array.
   assign w_rd_word  = w_in_range ? mem[w_idx] : '0;

   for (genvar i = 0; i < c_NB; i++) begin : g_lane_mask
      assign w_mask[8*i +: 8] = {8{mem_if.sel[i]}};
   end

   assign w_raw    = w_rd_word & w_mask;
   assign w_is_ext = (mem_if.ld_ext == 2'b01) || (mem_if.ld_ext == 2'b10);

   // Field decode: single lane, aligned lane pair, or full word (field = word).
   always_comb begin
      w_legal = 1'b0;
      w_off   = 0;
      w_fw    = 8;
      for (int k = 0; k < c_NB; k++) begin
         if (mem_if.sel == (c_NB'(1) << k)) begin
            w_legal = 1'b1;
            w_off   = k;
            w_fw    = 8;
         end
      end
      for (int k = 0; k < c_NB / 2; k++) begin
         if (mem_if.sel == (c_NB'(3) << (2 * k))) begin
            w_legal = 1'b1;
            w_off   = 2 * k;
            w_fw    = 16;
         end
      end
      if (&mem_if.sel) begin
         w_legal = 1'b1;
         w_off   = 0;
         w_fw    = DATA_W;
      end
   end

   always_comb begin
      w_shift    = w_rd_word >> (8 * w_off);
      w_msb      = 1'b0;
      w_ext_word = '0;
      for (int b = 0; b < DATA_W; b++) begin
         if (b == w_fw - 1) w_msb = w_shift[b];
      end
      w_sign = (mem_if.ld_ext == 2'b10) && w_msb;
      for (int b = 0; b < DATA_W; b++) begin
         w_ext_word[b] = (b < w_fw) ? w_shift[b] : w_sign;
      end
   end

   assign w_load_res = !w_in_range             ? '0 :
                       (w_is_ext && w_legal)   ? w_ext_word :
                                                 w_raw;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      w_we       = '0;
      w_waddr    = w_idx;
      w_wdata    = mem_if.data_in;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      addr_err_d = 1'b0;
      fmt_err_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_if.str && w_in_range) w_we = mem_if.sel;
            if (mem_if.ld) begin
               data_out_d = w_load_res;
               rd_valid_d = 1'b1;
            end
            addr_err_d = (mem_if.str || mem_if.ld) && !w_in_range;
            fmt_err_d  = mem_if.ld && w_is_ext && !w_legal;
            if (mem_if.clr) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            w_we    = '1;
            w_waddr = ptr_q;
            w_wdata = '0;
            if (ptr_q == c_LAST) begin
               state_d = S_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         fmt_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
         fmt_err_q  <= fmt_err_d;
      end
   end

   // Array has no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < c_NB; i++) begin
         if (w_we[i]) mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
   end

   assign mem_if.data_out = data_out_q;
   assign mem_if.rd_valid = rd_valid_q;
   assign mem_if.busy     = (state_q == S_CLEAR);
   assign mem_if.addr_err = addr_err_q;
   assign mem_if.fmt_err  = fmt_err_q;

endmodule
`default_nettype wire
